// File: rtl/piece_bag_scheduler.sv
// Turns the free-running piece generator into a 7-bag sequence and keeps a head + preview queue topped up.
// One draw per cycle while not full or on an accepted pop; all outputs come straight from registers.
module piece_bag_scheduler #(
    parameter int PREVIEW = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             rng_val,
    input  logic                   pop,
    output logic [2:0]             head,
    output logic                   head_valid,
    output logic [3*PREVIEW-1:0]   preview,
    output logic                   ready,
    output logic [6:0]             bag_used,
    output logic                   bag_refill
);

    localparam int D  = PREVIEW + 1;
    localparam int CW = $clog2(D + 1);

    logic [2:0]    q [D];
    logic [CW-1:0] count;

    logic          pop_acc;
    logic          draw;
    logic [2:0]    c;
    logic [2:0]    pick;
    logic          found;
    logic [3:0]    s;
    logic [6:0]    bag_or;

    logic [2:0]    q_n [D];
    logic [CW-1:0] cnt_n;

    assign head_valid = (count != '0);
    assign ready      = (count == CW'(D));
    assign head       = q[0];

    for (genvar k = 1; k <= PREVIEW; k++) begin : g_preview
        assign preview[3*k-1 -: 3] = q[k];
    end

    assign pop_acc = pop & head_valid;
    assign draw    = ~ready | pop_acc;

    // Scan c, c+1, ... (mod 7) for the first piece not yet taken from the bag.
    always_comb begin
        c     = (rng_val == 3'd7) ? 3'd6 : rng_val;
        pick  = 3'd0;
        found = 1'b0;
        s     = 4'd0;
        for (int i = 0; i < 7; i++) begin
            s = {1'b0, c} + 4'(i);
            if (s >= 4'd7) begin
                s = s - 4'd7;
            end
            if (!found && !bag_used[s[2:0]]) begin
                pick  = s[2:0];
                found = 1'b1;
            end
        end
        bag_or = bag_used | (7'd1 << pick);
    end

    // Shift first on a pop so the new piece lands at the (post-shift) tail.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            q_n[i] = q[i];
        end
        cnt_n = count;
        if (pop_acc) begin
            for (int i = 0; i < D - 1; i++) begin
                q_n[i] = q[i+1];
            end
            q_n[D-1] = 3'd0;
            cnt_n    = count - CW'(1);
        end
        if (draw) begin
            for (int i = 0; i < D; i++) begin
                if (cnt_n == CW'(i)) begin
                    q_n[i] = pick;
                end
            end
            cnt_n = cnt_n + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                q[i] <= 3'd0;
            end
            count      <= '0;
            bag_used   <= 7'd0;
            bag_refill <= 1'b0;
        end else begin
            for (int i = 0; i < D; i++) begin
                q[i] <= q_n[i];
            end
            count <= cnt_n;
            if (draw && bag_or == 7'h7F) begin
                bag_used   <= 7'd0;
                bag_refill <= 1'b1;
            end else begin
                if (draw) begin
                    bag_used <= bag_or;
                end
                bag_refill <= 1'b0;
            end
        end
    end

endmodule

// File: doc/piece_bag_scheduler.md
Name: piece_bag_scheduler

Overview:
Piece sequencer between the free-running 3-bit piece number generator and the game-control FSM. It turns the raw generator value into a 7-bag sequence, so every 7 consecutive draws from a bag boundary contain each piece 0..6 exactly once. It keeps a head-plus-preview queue that is refilled automatically. The game FSM consumes pieces with a single-cycle pop.

Parameters:
PREVIEW, 3, number of preview entries behind the head (legal 1..5); queue depth D = PREVIEW+1

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
rng_val  in  3  current generator output; legal 0..6, value 7 is treated as 6
pop  in  1  game consumes the head piece this cycle
head  out  3  piece at queue position 0
head_valid  out  1  queue holds at least 1 entry
preview  out  3*PREVIEW  entries 1..PREVIEW; entry k occupies bits [3k-1:3k-3]; invalid entries read 0
ready  out  1  queue full (count == D)
bag_used  out  7  one-hot mask of pieces already drawn from the current bag
bag_refill  out  1  1-cycle pulse, registered, asserted the cycle after the draw that completed a bag

Behaviour:
- State
  - Queue entries q[0..D-1], 3 bits each.
  - count: 0..D.
  - bag_used: 7 bits.
  - Control state FILL (count<D) or FULL (count==D). The state is derived from count; no separate register is required.
- Reset values
  - count=0, all q=0, bag_used=0, bag_refill=0.
  - Outputs: head=0, head_valid=0, ready=0, preview=0.
  - A reset asserted mid-operation discards the queue and the bag in the same way.
- Pop acceptance
  - pop is accepted only when head_valid=1.
  - pop while count==0 is ignored and leaves no side effects.
- Draw enable
  - draw = (count<D) | pop_accepted.
  - At most 1 draw per cycle.
- Draw selection
  - c = (rng_val==7) ? 6 : rng_val.
  - pick = first piece p in the order c, c+1, ..., wrapping mod 7, whose bag_used[p]==0.
  - Selection is purely combinational from the registered bag_used. A free slot always exists because a full mask is cleared before the next draw.
- Bag update on a draw
  - Normally bag_used <= bag_used | onehot(pick).
  - If that OR equals 7'h7F: bag_used <= 0 and bag_refill <= 1 next cycle.
  - Otherwise bag_refill <= 0.
- Queue update
  - Pop only: shift q[i] <= q[i+1], clear the top slot, count-1.
  - Draw only: q[count] <= pick, count+1.
  - Pop and draw in the same cycle: shift, then q[count-1] <= pick; count is unchanged.
- Latency
  - After reset deasserts, one draw per cycle; ready=1 exactly D cycles later.
  - In FULL, pop at cycle t gives the new head at t+1 and ready stays 1.
- Outputs
  - All outputs are registered or decoded directly from registers; none depend combinationally on pop or rng_val.
  - head_valid = (count!=0).
  - ready = (count==D).

Test Plan:
- Reset, then hold rng_val=3 → after 4 cycles: head=3, preview={4,5,6} (entry1=4), ready=1, bag_used=7'b1111000, bag_refill=0 throughout.
- From that state, rng_val=3, pop for 3 cycles → draws 0, 1, 2. The draw of 2 completes the bag:
  - bag_refill pulses once the following cycle.
  - bag_used returns to 0.
  - head sequence 4, 5, 6; ready stays 1.
- rng_val=7 held after reset → first draw is 6, then 0, 1, 2 (6 already used); head=6.
- pop asserted every cycle for 21 cycles with random rng_val in FULL → every aligned group of 7 drawn pieces is a permutation of 0..6; ready never drops.
- pop=1 immediately after reset (count=0) → ignored: count becomes 1, head = first draw.
- Assert reset when count=2 with bag_used nonzero → next cycle count=0, head_valid=0, bag_used=0, preview=0; refill restarts normally.
